// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and stall/squash statistics.
// master = upstream/control side driving the stage, slave = the stage register itself.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic              stat_clr;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        squash_cnt;

  modport master (
    output in_valid, in_data, out_ready, flush, stat_clr,
    input  in_ready, out_valid, out_data, stall_cnt, squash_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, stat_clr,
    output in_ready, out_valid, out_data, stall_cnt, squash_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register: main entry plus one skid entry so that
// in_ready is a pure state decode with no combinational path from out_ready.
module pipe_stage_skid #(
  parameter int                DATA_W  = 32,
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic            CLK,
  input  logic            nRST,
  pipe_stage_skid_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;
  logic [1:0]        squash_q;

  logic       in_ready;
  logic       out_valid;
  logic       in_fire;
  logic       out_fire;
  logic [1:0] held;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    held = 2'd0;
    case (state_q)
      ONE:     held = 2'd1;
      FULL:    held = 2'd2;
      default: held = 2'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= EMPTY;
      main_q   <= CLR_VAL;
      skid_q   <= CLR_VAL;
      stall_q  <= '0;
      squash_q <= 2'd0;
    end else begin
      // Stall statistics use pre-edge occupancy, so a stalled flush cycle still counts.
      if (bus.stat_clr) begin
        stall_q <= '0;
      end else if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end

      squash_q <= 2'd0;

      if (bus.flush) begin
        // A bundle consumed downstream in the flush cycle is not a squash.
        state_q  <= EMPTY;
        main_q   <= CLR_VAL;
        skid_q   <= CLR_VAL;
        squash_q <= held - {1'b0, out_fire};
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_q <= ONE;
              main_q  <= bus.in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_q <= bus.in_data;
            end else if (in_fire) begin
              state_q <= FULL;
              skid_q  <= bus.in_data;
            end else if (out_fire) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              state_q <= ONE;
              main_q  <= skid_q;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = main_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.squash_cnt = squash_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table for single-cycle behaviour,
// hand sequences for counter saturation and asynchronous reset.
module tb_pipe_stage_skid;

  localparam int          DW  = 8;
  localparam logic [7:0]  CLR = 8'hE5;

  logic CLK;
  logic nRST;

  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) bus  ();
  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(2))  bus2 ();

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .CLR_VAL(CLR)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(2), .CLR_VAL(CLR)) dut2 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus2.slave)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;
  assign bus2.flush     = bus.flush;
  assign bus2.stat_clr  = bus.stat_clr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       clr;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    int         e_st;
    logic [1:0] e_sq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                     input logic clr, input logic e_ov, input logic [7:0] e_od,
                     input logic e_ir, input int e_st, input logic [1:0] e_sq);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_st = e_st; v.e_sq = e_sq;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic clr);
    @(negedge CLK);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.stat_clr  = clr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //   iv  d      ordy fl clr | ov  od     ir  st sq
    // Streaming, zero bubbles
    add(1, 8'h11, 1, 0, 0,  1, 8'h11, 1, 0, 0);
    add(1, 8'h22, 1, 0, 0,  1, 8'h22, 1, 0, 0);
    add(1, 8'h33, 1, 0, 0,  1, 8'h33, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0,  0, 8'h33, 1, 0, 0);
    // Backpressure fills skid; 0xC held off until space frees
    add(1, 8'h0A, 0, 0, 0,  1, 8'h0A, 1, 0, 0);
    add(1, 8'h0B, 0, 0, 0,  1, 8'h0A, 0, 1, 0);
    add(1, 8'h0C, 0, 0, 0,  1, 8'h0A, 0, 2, 0);
    add(1, 8'h0C, 1, 0, 0,  1, 8'h0B, 1, 2, 0);
    add(1, 8'h0C, 1, 0, 0,  1, 8'h0C, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0,  0, 8'h0C, 1, 2, 0);
    // Flush while FULL with a competing in_fire
    add(1, 8'h0A, 0, 0, 0,  1, 8'h0A, 1, 2, 0);
    add(1, 8'h0B, 0, 0, 0,  1, 8'h0A, 0, 3, 0);
    add(1, 8'h0C, 0, 1, 0,  0, CLR,   1, 4, 2);
    add(0, 8'h00, 0, 0, 0,  0, CLR,   1, 4, 0);
    // Flush in ONE with simultaneous consume: nothing squashed
    add(1, 8'h05, 0, 0, 0,  1, 8'h05, 1, 4, 0);
    add(0, 8'h00, 1, 1, 0,  0, CLR,   1, 4, 0);
    // Flush in ONE while stalled: one squashed
    add(1, 8'h06, 0, 0, 0,  1, 8'h06, 1, 4, 0);
    add(0, 8'h00, 0, 1, 0,  0, CLR,   1, 5, 1);
    add(0, 8'h00, 0, 0, 0,  0, CLR,   1, 5, 0);
    add(0, 8'h00, 0, 0, 1,  0, CLR,   1, 0, 0);

    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.flush = 0; bus.stat_clr = 0;
    nRST = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_data",  {24'd0, bus.out_data},  {24'd0, CLR});
    chk("rst_stall",     {16'd0, bus.stall_cnt}, 32'd0);
    chk("rst_squash",    {30'd0, bus.squash_cnt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      $display("vec %0d: iv=%0b d=%02h ordy=%0b fl=%0b clr=%0b -> ov=%0b od=%02h ir=%0b st=%0d sq=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].clr,
               bus.out_valid, bus.out_data, bus.in_ready, bus.stall_cnt, bus.squash_cnt);
      chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_out_data", i),  {24'd0, bus.out_data},  {24'd0, vecs[i].e_od});
      chk($sformatf("v%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_stall", i),     {16'd0, bus.stall_cnt}, vecs[i].e_st);
      chk($sformatf("v%0d_squash", i),    {30'd0, bus.squash_cnt}, {30'd0, vecs[i].e_sq});
    end

    // Saturation: 2-bit counter stops at 3, 16-bit one keeps counting
    drive(1, 8'h77, 0, 0, 0);
    chk("sat_load_stall2", {30'd0, bus2.stall_cnt}, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      drive(0, 8'h00, 0, 0, 0);
      $display("sat cycle %0d: stall2=%0d stall16=%0d", c, bus2.stall_cnt, bus.stall_cnt);
      chk($sformatf("sat%0d_stall2", c),  {30'd0, bus2.stall_cnt}, (c > 3) ? 32'd3 : c);
      chk($sformatf("sat%0d_stall16", c), {16'd0, bus.stall_cnt}, c);
    end
    drive(0, 8'h00, 0, 0, 1);
    $display("stat_clr: stall2=%0d stall16=%0d", bus2.stall_cnt, bus.stall_cnt);
    chk("clr_stall2",  {30'd0, bus2.stall_cnt}, 32'd0);
    chk("clr_stall16", {16'd0, bus.stall_cnt},  32'd0);

    // Fill to FULL, then pulse reset between edges
    drive(1, 8'h88, 0, 0, 0);
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    chk("pre_rst_stall", {16'd0, bus.stall_cnt}, 32'd1);
    @(negedge CLK);
    bus.in_valid = 0;
    #1;
    nRST = 1'b0;
    #1;
    $display("async reset: ov=%0b od=%02h ir=%0b st=%0d", bus.out_valid, bus.out_data,
             bus.in_ready, bus.stall_cnt);
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_data",  {24'd0, bus.out_data},  {24'd0, CLR});
    chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("arst_stall",     {16'd0, bus.stall_cnt}, 32'd0);
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_arst_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
